// File: rtl/pattern_scan_pkg.sv
// rtl/pattern_scan_pkg.sv - shared types, default widths and length clamp for pattern_scan_ctrl
//
// Contents:
//   state_e    : controller states IDLE / SHIFT / REPORT
//   DEF_*      : default parameter values
//   LEN_W      : width of the pattern-length field
//   clamp_len  : forces a requested pattern length into 1..pat_max
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam int DEF_WORD_W  = 8;
    localparam int DEF_PAT_MAX = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int LEN_W       = 4;

    // A zero-length pattern would match every bit vacuously, so 0 is
    // promoted to 1; anything longer than the window is cut to the window.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int              pat_max);
        logic [LEN_W-1:0] res;
        if (len == '0) begin
            res = LEN_W'(1);
        end else if (int'(len) > pat_max) begin
            res = LEN_W'(pat_max);
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/pattern_window.sv
// rtl/pattern_window.sv - serial shift window, fill tracking and pattern match pulse
//
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   cfg_load      : load cfg_pattern/cfg_len (length clamped) and clear window/fill
//   cfg_pattern   : pattern, bit [len-1] oldest, bit 0 newest
//   cfg_len       : requested pattern length
//   shift_en      : shift bit_in into the window this edge
//   bit_in        : next serial bit
//   match         : combinational, the shift happening this edge completes a match
//   z             : registered match pulse, high the cycle after a matching shift
module pattern_window
    import pattern_scan_pkg::*;
#(
    parameter int PAT_MAX = DEF_PAT_MAX
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               shift_en,
    input  logic               bit_in,
    output logic               match,
    output logic               z
);

    logic [PAT_MAX-1:0] window_q, window_d;
    logic [PAT_MAX-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               z_q, z_d;
    logic               pat_eq;

    always_comb begin
        window_d  = window_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        fill_d    = fill_q;
        pat_eq    = 1'b1;
        match     = 1'b0;

        if (shift_en) begin
            window_d = {window_q[PAT_MAX-2:0], bit_in};
            if (fill_q < LEN_W'(PAT_MAX)) begin
                fill_d = fill_q + LEN_W'(1);
            end
            // Compare only the newest len_q bits of the post-shift window.
            for (int i = 0; i < PAT_MAX; i++) begin
                if ((LEN_W'(i) < len_q) && (window_d[i] != pattern_q[i])) begin
                    pat_eq = 1'b0;
                end
            end
            match = pat_eq && (fill_d >= len_q);
        end

        // Loads only occur while the controller is idle, so they never
        // collide with a shift.
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = clamp_len(cfg_len, PAT_MAX);
            window_d  = '0;
            fill_d    = '0;
        end

        // A match on the final bit of a word pulses during the first
        // REPORT cycle, one cycle after the shift like every other match.
        z_d = match;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            window_q  <= '0;
            pattern_q <= '0;
            len_q     <= LEN_W'(PAT_MAX);
            fill_q    <= '0;
            z_q       <= 1'b0;
        end else begin
            window_q  <= window_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            z_q       <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: rtl/pattern_scan_ctrl.sv
// rtl/pattern_scan_ctrl.sv - word-to-serial scan scheduler with per-word and total match counts
//
// Ports:
//   clock, reset              : rising-edge clock, asynchronous active-high reset
//   cfg_we/cfg_pattern/cfg_len: pattern configuration, accepted only in IDLE
//   in_valid/in_data/in_ready : input word handshake, word shifted LSB-first
//   out_valid/out_ready       : per-word result handshake
//   out_count                 : matches found in the reported word
//   total_count               : saturating running match total
//   clr_total                 : synchronous clear of total_count, wins over increment
//   z                         : registered one-cycle match pulse
//   busy                      : high whenever not IDLE
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int PAT_MAX = DEF_PAT_MAX,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               in_valid,
    input  logic [WORD_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   out_count,
    output logic [CNT_W-1:0]   total_count,
    input  logic               clr_total,
    output logic               z,
    output logic               busy
);

    localparam int              IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    logic                cfg_load;
    logic                shift_en;
    logic                match;

    assign cfg_load = cfg_we && (state_q == IDLE);
    assign shift_en = (state_q == SHIFT);

    pattern_window #(
        .PAT_MAX (PAT_MAX)
    ) u_window (
        .clock       (clock),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .shift_en    (shift_en),
        .bit_in      (data_q[0]),
        .match       (match),
        .z           (z)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        word_cnt_d = word_cnt_q;
        total_d    = total_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d     = in_data;
                    bit_idx_d  = '0;
                    word_cnt_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // The word register shifts right so bit 0 is always the next bit.
                data_d    = data_q >> 1;
                bit_idx_d = bit_idx_q + IDX_W'(1);
                if (match && (word_cnt_q != '1)) begin
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                end
                if (bit_idx_q == LAST_IDX) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr_total) begin
            total_d = '0;
        end else if (shift_en && match && (total_q != '1)) begin
            total_d = total_q + CNT_W'(1);
        end

        // Handshake outputs are registered from the next state.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == REPORT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            bit_idx_q   <= '0;
            word_cnt_q  <= '0;
            total_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            bit_idx_q   <= bit_idx_d;
            word_cnt_q  <= word_cnt_d;
            total_q     <= total_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign out_count   = word_cnt_q;
    assign total_count = total_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb/tb_pattern_scan_ctrl.sv - self-checking bench for pattern_scan_ctrl
module tb_pattern_scan_ctrl;

    localparam int WORD_W  = 8;
    localparam int PAT_MAX = 4;
    localparam int CNT_W   = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic               in_valid;
    logic [WORD_W-1:0]  in_data;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [CNT_W-1:0]   out_count;
    logic [CNT_W-1:0]   total_count;
    logic               clr_total;
    logic               z;
    logic               busy;

    pattern_scan_ctrl #(
        .WORD_W  (WORD_W),
        .PAT_MAX (PAT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .total_count (total_count),
        .clr_total   (clr_total),
        .z           (z),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         cfg;
        logic [3:0] pat;
        logic [3:0] len;
        logic [7:0] data;
        int         exp_cnt;
        int         exp_tot;
        logic [6:0] exp_z;
    } vec_t;

    typedef struct {
        int cnt;
        int tot;
    } exp_t;

    vec_t vecs[7];
    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard: each completed result handshake pops one expectation.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_out_count", int'(out_count), e.cnt);
                check("sb_total_count", int'(total_count), e.tot);
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic accept_word(input bit cfg, input logic [3:0] pat, input logic [3:0] len,
                               input logic [7:0] data, input bit push, input int exp_cnt,
                               input int exp_tot);
        int t = 0;
        @(negedge clock);
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        cfg_we      = cfg;
        cfg_pattern = pat;
        cfg_len     = len;
        in_valid    = 1'b1;
        in_data     = data;
        @(posedge clock);
        if (push) sb_q.push_back('{exp_cnt, exp_tot});
        #1;
        cfg_we   = 1'b0;
        in_valid = 1'b0;
    endtask

    // Called just after the acceptance edge; n counts edges until out_valid.
    task automatic wait_report(input bit chk, input logic [6:0] exp_z, input string name);
        int n = 0;
        int t = 0;
        logic [7:0] zm = '0;
        do begin
            @(posedge clock);
            #1;
            n++;
            if (n <= 8) zm[n-1] = z;
        end while (!out_valid && n < 40);
        if (!out_valid) check({name, "_report_timeout"}, 0, 1);
        if (chk) begin
            check({name, "_latency"}, n, WORD_W);
            check({name, "_z_pulses"}, int'(zm[6:0]), int'(exp_z));
        end
        while (out_valid && t < 40) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (out_valid) check({name, "_release_timeout"}, 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        clr_total   = 1'b0;

        vecs[0] = '{1'b1, 4'b0101, 4'd3, 8'b00010101, 2, 2,  7'b0010100};
        vecs[1] = '{1'b1, 4'b0101, 4'd3, 8'b01000000, 0, 2,  7'b0000000};
        vecs[2] = '{1'b0, 4'b0000, 4'd0, 8'b00000001, 1, 3,  7'b0000001};
        vecs[3] = '{1'b1, 4'b0011, 4'd2, 8'b00000111, 2, 5,  7'b0000110};
        vecs[4] = '{1'b1, 4'b1111, 4'd0, 8'b10110010, 4, 9,  7'b0110010};
        vecs[5] = '{1'b1, 4'b1001, 4'd9, 8'b01001001, 2, 11, 7'b1001000};
        vecs[6] = '{1'b1, 4'b0000, 4'd4, 8'b00000000, 5, 15, 7'b1111000};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_total", int'(total_count), 0);
        check("rst_z", int'(z), 0);
        check("rst_busy", int'(busy), 0);

        // Table: continuous stream, config writes clear the window.
        for (int i = 0; i < 7; i++) begin
            accept_word(vecs[i].cfg, vecs[i].pat, vecs[i].len, vecs[i].data, 1'b1,
                        vecs[i].exp_cnt, vecs[i].exp_tot);
            #1;
            check($sformatf("vec%0d_busy", i), int'(busy), 1);
            check($sformatf("vec%0d_in_ready", i), int'(in_ready), 0);
            wait_report(1'b1, vecs[i].exp_z, $sformatf("vec%0d", i));
        end

        // Backpressure in REPORT.
        do_reset();
        out_ready = 1'b0;
        accept_word(1'b1, 4'b0101, 4'd3, 8'b00010101, 1'b1, 2, 2);
        for (int t = 0; t < 30 && !out_valid; t++) begin
            @(posedge clock);
            #1;
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_count", int'(out_count), 2);
            check("bp_in_ready", int'(in_ready), 0);
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_release_out_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_busy", int'(busy), 0);

        // Config write mid-SHIFT is ignored; in IDLE it applies.
        do_reset();
        accept_word(1'b1, 4'b0101, 4'd3, 8'b00010101, 1'b1, 2, 2);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        cfg_we      = 1'b1;
        cfg_pattern = 4'b0011;
        cfg_len     = 4'd2;
        @(posedge clock);
        #1;
        cfg_we = 1'b0;
        wait_report(1'b0, 7'b0, "cfg_mid");
        @(negedge clock);
        cfg_we      = 1'b1;
        cfg_pattern = 4'b0011;
        cfg_len     = 4'd2;
        @(posedge clock);
        #1;
        cfg_we = 1'b0;
        accept_word(1'b0, 4'b0000, 4'd0, 8'b00000111, 1'b1, 2, 4);
        wait_report(1'b1, 7'b0000110, "cfg_idle");

        // Reset three cycles into SHIFT aborts the word.
        do_reset();
        accept_word(1'b1, 4'b0001, 4'd1, 8'hFF, 1'b0, 0, 0);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("pre_abort_total", int'(total_count), 3);
        reset = 1'b1;
        #1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out_count", int'(out_count), 0);
        check("abort_total", int'(total_count), 0);
        check("abort_z", int'(z), 0);
        check("abort_busy", int'(busy), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (12) @(negedge clock);
        check("abort_idle_busy", int'(busy), 0);
        // Reset config is pattern 0, length PAT_MAX.
        accept_word(1'b0, 4'b0000, 4'd0, 8'h00, 1'b1, 5, 5);
        wait_report(1'b1, 7'b1111000, "rst_cfg");

        // Saturation and clr_total priority.
        do_reset();
        accept_word(1'b1, 4'b0001, 4'd1, 8'hFF, 1'b1, 8, 8);
        wait_report(1'b1, 7'b1111111, "sat1");
        accept_word(1'b0, 4'b0000, 4'd0, 8'hFF, 1'b1, 8, 15);
        wait_report(1'b0, 7'b0, "sat2");
        check("sat_total", int'(total_count), 15);
        accept_word(1'b0, 4'b0000, 4'd0, 8'hFF, 1'b1, 8, 5);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        clr_total = 1'b1;
        @(posedge clock);
        #1;
        check("clr_on_match_total", int'(total_count), 0);
        clr_total = 1'b0;
        wait_report(1'b0, 7'b0, "clr");
        check("post_clr_total", int'(total_count), 5);
        @(negedge clock);
        clr_total = 1'b1;
        @(negedge clock);
        clr_total = 1'b0;
        check("idle_clr_total", int'(total_count), 0);

        repeat (2) @(negedge clock);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
